// File: rtl/grey_digit_monitor.sv
// Decodes a two-digit 10-state grey counter, checks that it only moves by legal steps,
// and drives a two-digit multiplexed seven-segment display from the decoded value.
module grey_digit_monitor #(
  parameter int unsigned REFRESH_DIV = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_ones,
  input  logic [4:0] i_tens,
  input  logic       i_clr_err,
  output logic [7:0] o_bcd,
  output logic       o_chg,
  output logic       o_err,
  output logic [3:0] o_err_cnt,
  output logic [6:0] o_seg,
  output logic [1:0] o_dig,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [15:0] SCAN_LAST = 16'(REFRESH_DIV - 1);

  function automatic logic [3:0] grey_dec(input logic [4:0] code);
    case (code)
      5'b00000: grey_dec = 4'd0;
      5'b00001: grey_dec = 4'd1;
      5'b00011: grey_dec = 4'd2;
      5'b00010: grey_dec = 4'd3;
      5'b00110: grey_dec = 4'd4;
      5'b00100: grey_dec = 4'd5;
      5'b01100: grey_dec = 4'd6;
      5'b01000: grey_dec = 4'd7;
      5'b11000: grey_dec = 4'd8;
      5'b10000: grey_dec = 4'd9;
      default:  grey_dec = 4'hF;
    endcase
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h40;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic [4:0]  smp_ones, smp_tens, prev_ones, prev_tens;
  logic        smp_vld;
  logic [15:0] scan_cnt, scan_nxt;
  logic [7:0]  bcd_nxt;
  logic        chg_nxt, err_nxt, scan_last;
  logic [3:0]  cnt_nxt;
  logic [6:0]  seg_nxt;
  logic [1:0]  dig_nxt;

  // Raw input sample plus the previous accepted sample it is checked against.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      smp_ones  <= 5'd0;
      smp_tens  <= 5'd0;
      smp_vld   <= 1'b0;
      prev_ones <= 5'd0;
      prev_tens <= 5'd0;
    end else begin
      smp_ones <= i_ones;
      smp_tens <= i_tens;
      smp_vld  <= 1'b1;
      if (smp_vld) begin
        prev_ones <= smp_ones;
        prev_tens <= smp_tens;
      end
    end
  end

  logic [3:0] dec_o, dec_t, pd_o, pd_t, pd_t_inc;
  logic       hold, all_legal, step_ones, wrap_tens, to_zero, seq_err;

  assign dec_o     = grey_dec(smp_ones);
  assign dec_t     = grey_dec(smp_tens);
  assign pd_o      = grey_dec(prev_ones);
  assign pd_t      = grey_dec(prev_tens);
  assign pd_t_inc  = (pd_t == 4'd9) ? 4'd0 : pd_t + 4'd1;
  assign hold      = (smp_ones == prev_ones) && (smp_tens == prev_tens);
  assign all_legal = (dec_o != 4'hF) && (dec_t != 4'hF) && (pd_o != 4'hF) && (pd_t != 4'hF);
  assign step_ones = all_legal && (pd_o != 4'd9) && (dec_o == pd_o + 4'd1) && (dec_t == pd_t);
  assign wrap_tens = all_legal && (pd_o == 4'd9) && (dec_o == 4'd0) && (dec_t == pd_t_inc);
  // A restart to 00 is accepted even when the previous sample held an illegal code.
  assign to_zero   = (dec_o == 4'd0) && (dec_t == 4'd0);
  assign seq_err   = smp_vld && (state != ST_PRIME) && !(hold || step_ones || wrap_tens || to_zero);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_PRIME;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PRIME: if (smp_vld) state_nxt = ST_TRACK;
      ST_TRACK: if (seq_err) state_nxt = ST_FAULT;
      ST_FAULT: if (i_clr_err && !seq_err) state_nxt = ST_TRACK;
      default:  state_nxt = ST_PRIME;
    endcase
  end

  always_comb begin
    bcd_nxt = o_bcd;
    err_nxt = o_err;
    cnt_nxt = o_err_cnt;
    if (smp_vld) bcd_nxt = {dec_t, dec_o};
    chg_nxt = (bcd_nxt != o_bcd);
    // An error on the clearing edge wins, leaving a count of exactly one.
    if (seq_err) begin
      err_nxt = 1'b1;
      if (i_clr_err)                cnt_nxt = 4'd1;
      else if (o_err_cnt != 4'hF)   cnt_nxt = o_err_cnt + 4'd1;
    end else if (i_clr_err) begin
      err_nxt = 1'b0;
      cnt_nxt = 4'd0;
    end
    scan_last = (scan_cnt == SCAN_LAST);
    scan_nxt  = scan_last ? 16'd0 : scan_cnt + 16'd1;
    dig_nxt   = scan_last ? {o_dig[0], o_dig[1]} : o_dig;
    seg_nxt   = seg_enc(dig_nxt[0] ? o_bcd[3:0] : o_bcd[7:4]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bcd     <= 8'h00;
      o_chg     <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= 4'd0;
      o_seg     <= 7'h00;
      o_dig     <= 2'b01;
      scan_cnt  <= 16'd0;
    end else begin
      o_bcd     <= bcd_nxt;
      o_chg     <= chg_nxt;
      o_err     <= err_nxt;
      o_err_cnt <= cnt_nxt;
      o_seg     <= seg_nxt;
      o_dig     <= dig_nxt;
      scan_cnt  <= scan_nxt;
    end
  end

  assign o_state = state;

endmodule

// File: doc/grey_digit_monitor.md
GREY_DIGIT_MONITOR -- requirements
Module: grey_digit_monitor

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 256, giving clock cycles per display digit slot (legal range 2..65535).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_ones  input  5  ones digit in the 10-state grey code, from the upstream two-digit grey counter, same clock domain.
REQ-005 SHALL have port i_tens  input  5  tens digit, same code and domain.
REQ-006 SHALL have port i_clr_err  input  1  synchronous clear of the error flag and error count.
REQ-007 SHALL have port o_bcd  output  8  decoded value; [7:4] tens, [3:0] ones, 4'hF for an illegal code.
REQ-008 SHALL have port o_chg  output  1  one-cycle pulse when o_bcd takes a new value.
REQ-009 SHALL have port o_err  output  1  sticky sequence-error flag.
REQ-010 SHALL have port o_err_cnt  output  4  saturating error count.
REQ-011 SHALL have port o_seg  output  7  active-high segments, bit0=a..bit6=g.
REQ-012 SHALL have port o_dig  output  2  one-hot digit enable; 01=ones, 10=tens.

Function
REQ-013 SHALL decode codes 00000,00001,00011,00010,00110,00100,01100,01000,11000,10000 to digits 0..9; all other codes decode to 4'hF.
REQ-014 SHALL register i_ones/i_tens at every edge k; o_bcd, o_chg, o_err and o_err_cnt reflect that sample at edge k+1 (2-edge input-to-output latency).
REQ-015 SHALL implement states PRIME, TRACK and FAULT.
REQ-016 PRIME: first registered sample after reset is accepted unchecked; o_bcd updated, o_chg pulses if the value differs from 8'h00; next state TRACK.
REQ-017 TRACK: each new sample is compared with the previous one; legal transitions are (a) hold, (b) ones advances one step with tens held, (c) ones 9->0 with tens advancing one step, including 99->00, (d) jump to 00 from any value (upstream restart).
REQ-018 SHALL treat any other transition, or any sample containing an illegal code, as an error: o_err<=1, o_err_cnt increments and saturates at 15, next state FAULT.
REQ-019 FAULT: decoding and checking continue, and further errors still increment o_err_cnt; the state returns to TRACK only on i_clr_err.
REQ-020 i_clr_err SHALL clear o_err and o_err_cnt at the next edge; if an error is detected on the same edge, the result SHALL be o_err=1, o_err_cnt=1 and state FAULT.
REQ-021 o_chg SHALL be high for exactly one cycle for each edge on which o_bcd changes, and low otherwise.
REQ-022 A free-running scan counter SHALL toggle o_dig every REFRESH_DIV cycles, starting at 01 after reset.
REQ-023 o_seg SHALL be registered each cycle from the o_bcd nibble selected by the next o_dig value, so o_seg and o_dig change on the same edge.
REQ-024 Segment encodings SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; nibble F shows a dash, 40.

Reset
REQ-025 On i_rst assertion, at any time including mid-scan or in FAULT, all outputs and state SHALL clear asynchronously: o_bcd=00, o_chg=0, o_err=0, o_err_cnt=0, o_seg=00, o_dig=01, scan counter=0, state=PRIME.
REQ-026 After i_rst deassertion, the first edge SHALL sample the inputs; o_seg SHALL show the decoded digit from the first scan update onward.

Verification
REQ-027 Reset mid-run in FAULT with o_err_cnt=5 -> all outputs at REQ-025 values immediately, with no clock edge required.
REQ-028 Drive the full legal sequence 00..99 then 00 -> o_bcd steps 00..99,00; 100 o_chg pulses; o_err stays 0.
REQ-029 Ones jumps 00001->00010 (1->3) -> o_err=1 and o_err_cnt=1 two edges after the input change; the next legal step adds no count.
REQ-030 Ones=00101 (illegal) held 3 cycles -> o_bcd[3:0]=F, o_seg=40 in the ones slot, exactly one error counted.
REQ-031 Value 47 followed by jump to 00/00 -> no error, o_chg pulse, o_bcd=00.
REQ-032 With REFRESH_DIV=4, 20 errors injected, then i_clr_err pulsed on the same edge as a new error -> o_dig toggles every 4 cycles; o_err_cnt saturates at 15, then reads 1 with o_err=1.
